// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the requester command record used by the
// multi-requester AHB master.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } ahb_cmd_t;

  typedef enum logic {
    D_EMPTY = 1'b0,
    D_DATA  = 1'b1
  } dslot_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last granted index and
// the pointer only moves when a grant is actually taken (en & |req).
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    int   idx;
    logic found;
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        ptr_d    = PW'(idx);
      end
    end
    if (!en) ptr_d = ptr_q;
  end

  // Reset to the last index so requester 0 is first in line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= PW'(N - 1);
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ahb_master_arbiter.sv
// Shares one AHB-Lite master port among NREQ valid/ready requesters using a
// two-slot (address / data phase) pipeline of single NONSEQ word transfers.
module ahb_master_arbiter
  import ahb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_write,
  input  logic [NREQ-1:0][31:0] req_addr,
  input  logic [NREQ-1:0][31:0] req_wdata,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic [31:0]          ahb_if_haddr,
  output logic                 ahb_if_hwrite,
  output logic [31:0]          ahb_if_hwdata,
  output logic [1:0]           ahb_if_htrans,
  output logic [2:0]           ahb_if_hsize,
  output logic [2:0]           ahb_if_hburst,
  output logic                 ahb_if_hsel,
  output logic                 ahb_if_hreadyin,
  input  logic                 ahb_if_hready,
  input  logic [31:0]          ahb_if_hrdata,
  input  logic [1:0]           ahb_if_hresp,
  output logic                 busy,
  output logic                 bus_timeout
);

  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  // A slot
  logic           a_nonseq_q, a_nonseq_d;
  ahb_cmd_t       a_cmd_q, a_cmd_d;
  logic [OW-1:0]  a_owner_q, a_owner_d;
  // D slot
  dslot_e         d_state_q, d_state_d;
  logic           d_write_q, d_write_d;
  logic [OW-1:0]  d_owner_q, d_owner_d;
  logic [31:0]    hwdata_q, hwdata_d;
  // response and timeout
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic            tmo_q, tmo_d;

  logic            adv, accept, d_done;
  logic [NREQ-1:0] gnt;
  logic [OW-1:0]   win_idx;
  ahb_cmd_t        win_cmd;

  // An empty pipeline advances even if the slave parks hready low.
  assign adv    = ahb_if_hready | (!a_nonseq_q && d_state_q == D_EMPTY);
  assign d_done = (d_state_q == D_DATA) && ahb_if_hready;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (req_valid),
    .en  (adv),
    .gnt (gnt)
  );

  assign req_ready = adv ? gnt : '0;
  assign accept    = |(req_valid & req_ready);

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) win_idx = OW'(i);
    end
    win_cmd.write = req_write[win_idx];
    win_cmd.addr  = {req_addr[win_idx][31:2], 2'b00};
    win_cmd.wdata = req_wdata[win_idx];
  end

  always_comb begin
    a_nonseq_d  = a_nonseq_q;
    a_cmd_d     = a_cmd_q;
    a_owner_d   = a_owner_q;
    d_state_d   = d_state_q;
    d_write_d   = d_write_q;
    d_owner_d   = d_owner_q;
    hwdata_d    = hwdata_q;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    tmo_cnt_d   = tmo_cnt_q;
    tmo_d       = tmo_q;

    if (d_done) begin
      rsp_valid_d[d_owner_q] = 1'b1;
      rsp_rdata_d            = d_write_q ? 32'h0 : ahb_if_hrdata;
      rsp_err_d              = (ahb_if_hresp == HRESP_ERROR);
    end

    if (adv) begin
      d_state_d  = a_nonseq_q ? D_DATA : D_EMPTY;
      d_write_d  = a_cmd_q.write;
      d_owner_d  = a_owner_q;
      hwdata_d   = (a_nonseq_q && a_cmd_q.write) ? a_cmd_q.wdata : 32'h0;
      a_nonseq_d = accept;
      if (accept) begin
        a_cmd_d   = win_cmd;
        a_owner_d = win_idx;
      end
    end

    // Saturating wait-state counter; the flag is sticky until reset.
    if (ahb_if_hready) begin
      tmo_cnt_d = '0;
    end else if (d_state_q == D_DATA) begin
      if (tmo_cnt_q != TW'(TIMEOUT)) tmo_cnt_d = tmo_cnt_q + 1'b1;
      if (tmo_cnt_q >= TW'(TIMEOUT - 1)) tmo_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_nonseq_q  <= 1'b0;
      a_cmd_q     <= '0;
      a_owner_q   <= '0;
      d_state_q   <= D_EMPTY;
      d_write_q   <= 1'b0;
      d_owner_q   <= '0;
      hwdata_q    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      tmo_cnt_q   <= '0;
      tmo_q       <= 1'b0;
    end else begin
      a_nonseq_q  <= a_nonseq_d;
      a_cmd_q     <= a_cmd_d;
      a_owner_q   <= a_owner_d;
      d_state_q   <= d_state_d;
      d_write_q   <= d_write_d;
      d_owner_q   <= d_owner_d;
      hwdata_q    <= hwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      tmo_cnt_q   <= tmo_cnt_d;
      tmo_q       <= tmo_d;
    end
  end

  assign ahb_if_htrans   = a_nonseq_q ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign ahb_if_haddr    = a_cmd_q.addr;
  assign ahb_if_hwrite   = a_cmd_q.write;
  assign ahb_if_hwdata   = hwdata_q;
  assign ahb_if_hsel     = a_nonseq_q;
  assign ahb_if_hsize    = HSIZE_WORD;
  assign ahb_if_hburst   = HBURST_SINGLE;
  assign ahb_if_hreadyin = ahb_if_hready;

  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign busy        = a_nonseq_q | (d_state_q == D_DATA);
  assign bus_timeout = tmo_q;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Bench for ahb_master_arbiter: a behavioural AHB slave with per-address wait
// and error settings, plus a scoreboard of expected responses and write data.
module tb_ahb_master_arbiter;
  import ahb_pkg::*;

  localparam int NREQ = 2;
  localparam int TMO  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]       req_valid = '0, req_ready, req_write = '0, rsp_valid;
  logic [NREQ-1:0][31:0] req_addr = '0, req_wdata = '0;
  logic [31:0] rsp_rdata, haddr, hwdata, hrdata;
  logic        rsp_err, hwrite, hsel, hreadyin, hready, busy, bus_timeout;
  logic [1:0]  htrans, hresp;
  logic [2:0]  hsize, hburst;

  ahb_master_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ahb_if_haddr(haddr), .ahb_if_hwrite(hwrite), .ahb_if_hwdata(hwdata),
    .ahb_if_htrans(htrans), .ahb_if_hsize(hsize), .ahb_if_hburst(hburst),
    .ahb_if_hsel(hsel), .ahb_if_hreadyin(hreadyin),
    .ahb_if_hready(hready), .ahb_if_hrdata(hrdata), .ahb_if_hresp(hresp),
    .busy(busy), .bus_timeout(bus_timeout)
  );

  // ---------------- slave model ----------------
  int          cfg_wait [logic [31:0]];
  bit          cfg_err  [logic [31:0]];
  logic [31:0] cfg_rd   [logic [31:0]];

  function automatic logic [31:0] rd_fn(logic [31:0] a);
    return cfg_rd.exists(a) ? cfg_rd[a] : (a ^ 32'h5A5A_0F0F);
  endfunction

  logic        dp_act, dp_write, dp_err;
  logic [31:0] dp_addr, dp_rdata;
  int          dp_wleft;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_act <= 1'b0; dp_write <= 1'b0; dp_err <= 1'b0;
      dp_addr <= '0; dp_rdata <= '0; dp_wleft <= 0;
    end else if (hready) begin
      dp_act   <= (htrans == HTRANS_NONSEQ) && hsel;
      dp_addr  <= haddr;
      dp_write <= hwrite;
      dp_wleft <= cfg_wait.exists(haddr) ? cfg_wait[haddr] : 0;
      dp_err   <= cfg_err.exists(haddr) && cfg_err[haddr];
      dp_rdata <= rd_fn(haddr);
    end else begin
      dp_wleft <= dp_wleft - 1;
    end
  end

  assign hready = !dp_act || (dp_wleft == 0);
  assign hresp  = (dp_act && dp_err && dp_wleft <= 1) ? HRESP_ERROR : HRESP_OKAY;
  // Junk on non-read cycles so a leaked hrdata shows up in write responses.
  assign hrdata = (dp_act && !dp_write) ? dp_rdata : 32'hBAD0_0000;

  // ---------------- scoreboard ----------------
  typedef struct {
    int          owner;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] wr_q[$];
  int          acc_who[$];
  int          acc_cyc[$];
  int          total = 0;
  int          bad   = 0;

  function automatic void expect_cmd(int i, logic w, logic [31:0] a, logic [31:0] d);
    exp_t        e;
    logic [31:0] al;
    al      = {a[31:2], 2'b00};
    e.owner = i;
    e.rdata = w ? 32'h0 : rd_fn(al);
    e.err   = cfg_err.exists(al) && cfg_err[al];
    exp_q.push_back(e);
    if (w) wr_q.push_back(d);
  endfunction

  task automatic monitor();
    exp_t            e;
    logic [31:0]     w;
    logic [NREQ-1:0] ev;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (dp_act && dp_write && hready) begin
          total++;
          if (wr_q.size() == 0) begin
            bad++; $display("FAIL hwdata_unexpected got=%h", hwdata);
          end else begin
            w = wr_q.pop_front();
            if (hwdata !== w) begin
              bad++; $display("FAIL hwdata got=%h exp=%h", hwdata, w);
            end
          end
        end
        if (rsp_valid !== '0) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++; $display("FAIL rsp_unexpected rsp_valid=%b", rsp_valid);
          end else begin
            e  = exp_q.pop_front();
            ev = '0;
            ev[e.owner] = 1'b1;
            if (rsp_valid !== ev || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
              bad++;
              $display("FAIL rsp_sb got v=%b rd=%h err=%b exp v=%b rd=%h err=%b",
                       rsp_valid, rsp_rdata, rsp_err, ev, e.rdata, e.err);
            end
          end
        end
      end
    end
  endtask

  // Drive at a negedge, hold until accepted, return at the negedge after accept.
  task automatic issue(int i, logic w, logic [31:0] a, logic [31:0] d, bit keep);
    int n = 0;
    req_valid[i] = 1'b1; req_write[i] = w; req_addr[i] = a; req_wdata[i] = d;
    #1;
    while (!req_ready[i] && n < 200) begin
      @(negedge clk); #1; n++;
    end
    total++;
    if (!req_ready[i]) begin
      bad++; $display("FAIL accept_wait req%0d ready=%b exp=1", i, req_ready[i]);
      req_valid[i] = 1'b0;
      return;
    end
    expect_cmd(i, w, a, d);
    acc_who.push_back(i);
    acc_cyc.push_back(cyc);
    @(negedge clk);
    if (!keep) req_valid[i] = 1'b0;
  endtask

  task automatic check_reset_outputs(string tag);
    total++;
    if ({htrans, haddr, hwrite, hwdata, hsel, hsize, hburst} !==
        {2'b00, 32'h0, 1'b0, 32'h0, 1'b0, 3'b010, 3'b000}) begin
      bad++;
      $display("FAIL %s_ahb got htrans=%b haddr=%h hwrite=%b hwdata=%h hsel=%b hsize=%b hburst=%b",
               tag, htrans, haddr, hwrite, hwdata, hsel, hsize, hburst);
    end
    total++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_err, busy, bus_timeout, hreadyin} !==
        {2'b00, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL %s_ctl got rdy=%b rv=%b rd=%h err=%b busy=%b tmo=%b hri=%b exp all 0 (hri=1)",
               tag, req_ready, rsp_valid, rsp_rdata, rsp_err, busy, bus_timeout, hreadyin);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk); #1;
    check_reset_outputs("post_reset");
  endtask

  task automatic test_write();
    int lat = 1;
    issue(0, 1'b1, 32'h0001_0000, 32'hDEAD_BEEF, 1'b0);
    #1;
    total++;
    if ({htrans, haddr, hwrite, hsel} !== {HTRANS_NONSEQ, 32'h0001_0000, 1'b1, 1'b1}) begin
      bad++; $display("FAIL wr_addr_phase got htrans=%b haddr=%h hwrite=%b hsel=%b", htrans, haddr, hwrite, hsel);
    end
    @(negedge clk); #1; lat++;
    total++;
    if (htrans !== HTRANS_IDLE || hwdata !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL wr_data_phase got htrans=%b hwdata=%h exp 00/deadbeef", htrans, hwdata);
    end
    @(negedge clk); #1; lat++;
    total++;
    if (rsp_valid !== 2'b01 || rsp_err !== 1'b0 || lat != 3) begin
      bad++; $display("FAIL wr_latency got rv=%b err=%b lat=%0d exp 01/0/3", rsp_valid, rsp_err, lat);
    end
    @(negedge clk); #1;
    total++;
    if (rsp_valid !== 2'b00 || hwdata !== 32'h0 || busy !== 1'b0) begin
      bad++; $display("FAIL wr_idle got rv=%b hwdata=%h busy=%b exp 00/0/0", rsp_valid, hwdata, busy);
    end
  endtask

  task automatic test_read_wait();
    int lat = 1;
    cfg_wait[32'h0005_0004] = 3;
    cfg_rd[32'h0005_0004]   = 32'h1234_5678;
    issue(1, 1'b0, 32'h0005_0004, 32'h0, 1'b0);
    #1;
    while (!rsp_valid[1] && lat < 20) begin
      @(negedge clk); #1; lat++;
    end
    total++;
    if (lat != 6 || rsp_rdata !== 32'h1234_5678 || rsp_err !== 1'b0) begin
      bad++; $display("FAIL rd_wait got lat=%0d rd=%h err=%b exp 6/12345678/0", lat, rsp_rdata, rsp_err);
    end
  endtask

  task automatic stream(int i, int n);
    for (int k = 0; k < n; k++)
      issue(i, k[0], 32'h1000_0000 + 32'(i * 256 + k * 4 + (k % 4)),
            32'hC0DE_0000 + 32'(i * 16 + k), k < n - 1);
  endtask

  task automatic test_back_to_back();
    int s = acc_who.size();
    fork
      stream(0, 8);
      stream(1, 8);
    join
    total++;
    if (acc_who.size() != s + 16) begin
      bad++; $display("FAIL b2b_count got=%0d exp=16", acc_who.size() - s);
    end else begin
      for (int k = 1; k < 16; k++) begin
        total++;
        if (acc_who[s + k] != (k % 2) || acc_cyc[s + k] != acc_cyc[s + k - 1] + 1) begin
          bad++;
          $display("FAIL b2b_grant k=%0d got who=%0d dcyc=%0d exp who=%0d dcyc=1",
                   k, acc_who[s + k], acc_cyc[s + k] - acc_cyc[s + k - 1], k % 2);
        end
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_error();
    bit seen0 = 0, seen1 = 0;
    logic e0 = 1'b0, e1 = 1'b1;
    cfg_wait[32'h0002_0000] = 1;
    cfg_err[32'h0002_0000]  = 1'b1;
    fork
      issue(0, 1'b1, 32'h0002_0000, 32'hFACE_0001, 1'b0);
      issue(1, 1'b0, 32'h0002_0010, 32'h0, 1'b0);
    join
    for (int n = 0; n < 15; n++) begin
      #1;
      if (rsp_valid[0]) begin seen0 = 1; e0 = rsp_err; end
      if (rsp_valid[1]) begin seen1 = 1; e1 = rsp_err; end
      @(negedge clk);
    end
    total++;
    if (!seen0 || !seen1 || e0 !== 1'b1 || e1 !== 1'b0) begin
      bad++; $display("FAIL err_pipe got seen=%0d%0d err0=%b err1=%b exp 11/1/0", seen0, seen1, e0, e1);
    end
  endtask

  task automatic test_timeout();
    int lows = 0, n = 0;
    bit low_now;
    cfg_wait[32'h0003_0000] = TMO + 4;
    issue(0, 1'b0, 32'h0003_0000, 32'h0, 1'b0);
    #1;
    while (!rsp_valid[0] && n < 100) begin
      low_now = dp_act && !hready;
      @(negedge clk); #1; n++;
      if (low_now) begin
        lows++;
        if (lows == TMO - 1) begin
          total++;
          if (bus_timeout !== 1'b0) begin
            bad++; $display("FAIL tmo_early lows=%0d got=%b exp=0", lows, bus_timeout);
          end
        end
        if (lows == TMO) begin
          total++;
          if (bus_timeout !== 1'b1) begin
            bad++; $display("FAIL tmo_rise lows=%0d got=%b exp=1", lows, bus_timeout);
          end
        end
      end
    end
    total++;
    if (!rsp_valid[0] || lows != TMO + 4) begin
      bad++; $display("FAIL tmo_complete got rv=%b lows=%0d exp 1/%0d", rsp_valid[0], lows, TMO + 4);
    end
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (bus_timeout !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL tmo_sticky got tmo=%b busy=%b exp 1/0", bus_timeout, busy);
    end
  endtask

  task automatic test_midreset();
    int pulses = 0;
    int s;
    cfg_wait[32'h0004_0000] = 10;
    issue(0, 1'b0, 32'h0004_0000, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    wr_q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 12; n++) begin
      #1;
      if (rsp_valid !== '0) pulses++;
      @(negedge clk);
    end
    total++;
    if (pulses != 0) begin
      bad++; $display("FAIL midreset_rsp got pulses=%0d exp=0", pulses);
    end
    s = acc_who.size();
    fork
      issue(0, 1'b0, 32'h0006_0000, 32'h0, 1'b0);
      issue(1, 1'b0, 32'h0006_0100, 32'h0, 1'b0);
    join
    total++;
    if (acc_who.size() < s + 1 || acc_who[s] != 0) begin
      bad++; $display("FAIL midreset_first_grant got=%0d exp=0", (acc_who.size() > s) ? acc_who[s] : -1);
    end
    repeat (8) @(negedge clk);
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_write();
    test_read_wait();
    test_back_to_back();
    test_error();
    test_timeout();
    test_midreset();
    total++;
    if (exp_q.size() != 0 || wr_q.size() != 0) begin
      bad++; $display("FAIL drain got rsp_left=%0d wr_left=%0d exp 0/0", exp_q.size(), wr_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
